// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register and data-memory req/ack controller (LEGv8).
// Optional MISALIGN_CHECK_EN: misaligned accesses skip memory and flag misalign_M.
module ex_mem_stage #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] aluResult_E,
  input  logic [N-1:0] writeData_E,
  input  logic [N-1:0] PCBranch_E,
  input  logic         zero_E,
  input  logic         Branch_E,
  input  logic         memRead_E,
  input  logic         memWrite_E,
  input  logic         regWrite_E,
  input  logic         memtoReg_E,
  input  logic [4:0]   rd_E,
  input  logic         flush_M,
  output logic         dm_req,
  output logic         dm_we,
  output logic [N-1:0] dm_addr,
  output logic [N-1:0] dm_wdata,
  input  logic         dm_ack,
  input  logic [N-1:0] dm_rdata,
  output logic [N-1:0] aluResult_M,
  output logic [N-1:0] PCBranch_M,
  output logic [N-1:0] readData_M,
  output logic         regWrite_M,
  output logic         memtoReg_M,
  output logic [4:0]   rd_M,
  output logic         PCSrc_M,
  output logic         stall_M,
  output logic         misalign_M
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    COMPLETE
  } state_e;

  state_e       state_q;
  logic [N-1:0] aluResult_q;
  logic [N-1:0] writeData_q;
  logic [N-1:0] PCBranch_q;
  logic [N-1:0] readData_q;
  logic         zero_q;
  logic         branch_q;
  logic         memRead_q;
  logic         memWrite_q;
  logic         regWrite_q;
  logic         memtoReg_q;
  logic [4:0]   rd_q;
  logic         misalign_q;

  logic         advance;
  logic         mem_op_E;
  logic         mis_E;

  assign advance  = (state_q != ACCESS);
  assign mem_op_E = (memRead_E | memWrite_E) & ~flush_M;

`ifdef MISALIGN_CHECK_EN
  assign mis_E = mem_op_E & (|aluResult_E[2:0]);
`else
  assign mis_E = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      aluResult_q <= '0;
      writeData_q <= '0;
      PCBranch_q  <= '0;
      readData_q  <= '0;
      zero_q      <= 1'b0;
      branch_q    <= 1'b0;
      memRead_q   <= 1'b0;
      memWrite_q  <= 1'b0;
      regWrite_q  <= 1'b0;
      memtoReg_q  <= 1'b0;
      rd_q        <= '0;
      misalign_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, COMPLETE: begin
          if (flush_M) begin
            aluResult_q <= '0;
            writeData_q <= '0;
            PCBranch_q  <= '0;
            zero_q      <= 1'b0;
            branch_q    <= 1'b0;
            memRead_q   <= 1'b0;
            memWrite_q  <= 1'b0;
            regWrite_q  <= 1'b0;
            memtoReg_q  <= 1'b0;
            rd_q        <= '0;
            misalign_q  <= 1'b0;
          end else begin
            aluResult_q <= aluResult_E;
            writeData_q <= writeData_E;
            PCBranch_q  <= PCBranch_E;
            zero_q      <= zero_E;
            branch_q    <= Branch_E;
            memRead_q   <= memRead_E;
            memWrite_q  <= memWrite_E;
            regWrite_q  <= regWrite_E & ~mis_E;
            memtoReg_q  <= memtoReg_E;
            rd_q        <= rd_E;
            misalign_q  <= mis_E;
          end
          // A misaligned op retires through COMPLETE without a request
          if (mis_E)         state_q <= COMPLETE;
          else if (mem_op_E) state_q <= ACCESS;
          else               state_q <= IDLE;
        end
        ACCESS: begin
          if (dm_ack) begin
            if (memRead_q) readData_q <= dm_rdata;
            state_q <= COMPLETE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dm_req      = (state_q == ACCESS);
  assign stall_M     = (state_q == ACCESS);
  assign dm_we       = memWrite_q;
  assign dm_addr     = aluResult_q;
  assign dm_wdata    = writeData_q;
  assign aluResult_M = aluResult_q;
  assign PCBranch_M  = PCBranch_q;
  assign readData_M  = readData_q;
  assign regWrite_M  = regWrite_q;
  assign memtoReg_M  = memtoReg_q;
  assign rd_M        = rd_q;
  assign PCSrc_M     = branch_q & zero_q;
  assign misalign_M  = misalign_q;

endmodule
